cadu_frame_sync: RTL and testbench
==================================

Name: cadu_frame_sync

Overview:
- Sits directly downstream of the Viterbi decoder and consumes its serial decoded bit stream (vit_desc / valid_out_vit).
- Searches for the 32-bit CCSDS attached sync marker 0x1ACFFC1D, or its bitwise complement, which arises from a QPSK phase ambiguity.
- Once a marker is found, emits the following CADU payload as bytes with start/end-of-frame flags.
- Tracks lock with a flywheel so isolated marker corruption does not drop sync; output feeds the derandomizer / Reed-Solomon stage.

Parameters:
- ASM, 32'h1ACFFC1D, sync marker; MSB is received first.
- FRAME_BYTES, 1020, payload bytes between markers.
- SEARCH_THRESH, 0, max Hamming distance accepted while searching.
- LOCK_THRESH, 4, max Hamming distance accepted at the expected marker position while locked.
- MAX_MISSES, 3, consecutive failed marker checks before lock is dropped.

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- bit_in  in  1  decoded bit from Viterbi
- valid_in  in  1  bit_in qualifier; may be gapped arbitrarily
- byte_out  out  8  payload byte, polarity-corrected, first bit in MSB
- valid_out  out  1  one-cycle strobe per byte
- sof_out  out  1  high with the first payload byte of a frame
- eof_out  out  1  high with byte FRAME_BYTES of a frame
- locked  out  1  high whenever state != SEARCH
- inverted  out  1  latched polarity of the current lock
- frame_count  out  16  count of completed frames (eof), wraps at 0xFFFF->0

Behaviour:
- Reset values:
  - All outputs, the shift register, counters and miss_cnt = 0.
  - State = SEARCH.
  - Reset mid-frame aborts the frame immediately; no eof is produced.
- Shift register:
  - On valid_in, sr <= {sr[30:0], bit_in}.
  - Correlation uses the post-shift value sr_n = {sr[30:0], bit_in}.
  - d = popcount(sr_n ^ ASM); d_inv = popcount(sr_n ^ ~ASM), each 6 bits.
- When valid_in is low, no state, counter or sr change occurs, and valid_out/sof_out/eof_out are 0.
- SEARCH:
  - On valid_in, if d <= SEARCH_THRESH: go to DATA, inverted <= 0.
  - Else if d_inv <= SEARCH_THRESH: go to DATA, inverted <= 1.
  - The true polarity wins if both match.
  - On entry to DATA: bit_cnt = 0, byte_cnt = 0, miss_cnt = 0.
- DATA:
  - Each valid bit, XORed with inverted, is shifted into the byte assembler.
  - On the 8th bit, byte_out/valid_out are registered and appear the cycle after the valid_in carrying that bit (latency 1).
  - sof_out accompanies byte_cnt == 0; eof_out accompanies byte_cnt == FRAME_BYTES-1.
  - frame_count increments on the same cycle eof_out is driven.
  - After the eof byte, go to CHECK with chk_cnt = 0.
- CHECK:
  - Count 32 valid bits; no bytes are output.
  - On the 32nd bit, evaluate only the latched polarity: d (inverted=0) or d_inv (inverted=1) against LOCK_THRESH.
  - Pass: miss_cnt <= 0, go to DATA.
  - Fail: miss_cnt + 1. If this equals MAX_MISSES, go to SEARCH (locked drops next cycle, inverted held until next acquisition). Otherwise go to DATA (flywheel) with the frame emitted normally.
  - Polarity never changes while locked.
- Bits received in the SEARCH cycle that completes a marker are not payload. The first payload bit is the next valid bit.
- Counter widths: byte_cnt = $clog2(FRAME_BYTES), bit_cnt = 3, chk_cnt = 5, miss_cnt = $clog2(MAX_MISSES+1).
- No backpressure. Downstream must accept one byte per 8 valid_in cycles.

Decomposition:
- Shared package lrpt_pkg:
  - ASM_WORD constant.
  - CADU_PAYLOAD_BYTES constant (1020).
  - sync_state_t enum {SEARCH, DATA, CHECK}.
- Sub-module asm_correlator:
  - Combinational; takes sr_n and produces d and d_inv via two 32-bit popcounts.
  - Reused later by the bench model.

Test Plan:
- Reset: hold sys_rst_n=0 with random bit_in/valid_in -> all outputs 0, locked=0, frame_count=0. Assert reset mid-frame at byte 500 -> outputs 0 immediately, SEARCH, no eof.
- Clean frame: 16 random bits, ASM, bytes 0x00..0xFB repeating (1020 bytes), ASM, second frame, all valid_in=1 -> locked high after ASM; sof with 0x00; eof with byte 1020; frame_count=2; 2040 valid_out pulses; miss_cnt stays 0.
- Inverted: ~ASM followed by complemented payload -> inverted=1; byte_out identical to the clean case.
- Thresholds:
  - In SEARCH, ASM with 1 bit error -> no lock.
  - In CHECK, 4 bit errors -> pass, next frame output.
  - In CHECK, 5 errors -> miss_cnt=1, next frame still output.
- Flywheel loss: three consecutive markers with 8 bit errors -> frames after misses 1 and 2 are output; after the 3rd check, locked=0 and no valid_out. A following clean ASM reacquires.
- Gapped input: valid_in random 40% duty over two frames -> byte stream and frame_count identical to the ungapped case; valid_out never asserted in a cycle following valid_in=0.

Source files
------------

// File: rtl/lrpt_pkg.sv
// Shared definitions for the LRPT receive chain.
// Contents: attached sync marker word, CADU payload length, frame-sync state
// encoding and a 32-bit popcount helper used by the marker correlator.
package lrpt_pkg;

  localparam logic [31:0] ASM_WORD           = 32'h1ACFFC1D;
  localparam int          CADU_PAYLOAD_BYTES = 1020;

  typedef enum logic [1:0] {
    SEARCH,
    DATA,
    CHECK
  } sync_state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/asm_correlator.sv
// Combinational sync-marker correlator.
// Ports:
//   sr_n   in  32  candidate window, oldest bit in MSB
//   d      out  6  Hamming distance to ASM
//   d_inv  out  6  Hamming distance to ~ASM (QPSK phase-inverted marker)
module asm_correlator
  import lrpt_pkg::*;
#(
  parameter logic [31:0] ASM = ASM_WORD
) (
  input  logic [31:0] sr_n,
  output logic [5:0]  d,
  output logic [5:0]  d_inv
);

  assign d     = popcount32(sr_n ^ ASM);
  assign d_inv = popcount32(sr_n ^ ~ASM);

endmodule

// File: rtl/cadu_frame_sync.sv
// CADU frame synchronizer behind the Viterbi decoder.
// Hunts for the attached sync marker (either polarity), then emits the
// payload as bytes with sof/eof, re-checking the marker at each frame
// boundary and keeping lock through up to MAX_MISSES-1 consecutive misses.
// Ports:
//   clk          in   1   system clock
//   sys_rst_n    in   1   async active-low reset
//   bit_in       in   1   decoded bit
//   valid_in     in   1   bit_in qualifier, arbitrary gaps allowed
//   byte_out     out  8   payload byte, polarity corrected, first bit in MSB
//   valid_out    out  1   one-cycle strobe per byte
//   sof_out      out  1   first payload byte of a frame
//   eof_out      out  1   last payload byte of a frame
//   locked       out  1   not searching
//   inverted     out  1   polarity of the current / last lock
//   frame_count  out 16   completed frames, wrapping
module cadu_frame_sync
  import lrpt_pkg::*;
#(
  parameter logic [31:0] ASM           = ASM_WORD,
  parameter int          FRAME_BYTES   = CADU_PAYLOAD_BYTES,
  parameter int          SEARCH_THRESH = 0,
  parameter int          LOCK_THRESH   = 4,
  parameter int          MAX_MISSES    = 3
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        bit_in,
  input  logic        valid_in,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  output logic        sof_out,
  output logic        eof_out,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_count
);

  localparam int BCW = $clog2(FRAME_BYTES);
  localparam int MCW = $clog2(MAX_MISSES + 1);

  localparam logic [5:0]     S_TH       = 6'(SEARCH_THRESH);
  localparam logic [5:0]     L_TH       = 6'(LOCK_THRESH);
  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(FRAME_BYTES - 1);
  localparam logic [MCW-1:0] MISS_LIMIT = MCW'(MAX_MISSES);

  sync_state_t    state;
  // Only 31 history bits are kept; the incoming bit completes the window.
  logic [30:0]    sr;
  logic [31:0]    sr_n;
  logic [5:0]     d, d_inv, d_sel;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [4:0]     chk_cnt;
  logic [MCW-1:0] miss_cnt, miss_nxt;
  logic [6:0]     byte_acc;
  logic           pbit;
  logic [7:0]     byte_nxt;

  assign sr_n     = {sr, bit_in};
  assign pbit     = bit_in ^ inverted;
  assign byte_nxt = {byte_acc, pbit};
  // Once locked only the acquired polarity is ever trusted.
  assign d_sel    = inverted ? d_inv : d;
  assign miss_nxt = miss_cnt + 1'b1;
  assign locked   = (state != SEARCH);

  asm_correlator #(.ASM(ASM)) u_corr (
    .sr_n  (sr_n),
    .d     (d),
    .d_inv (d_inv)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= SEARCH;
      sr          <= '0;
      inverted    <= 1'b0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      chk_cnt     <= '0;
      miss_cnt    <= '0;
      byte_acc    <= '0;
      byte_out    <= '0;
      valid_out   <= 1'b0;
      sof_out     <= 1'b0;
      eof_out     <= 1'b0;
      frame_count <= '0;
    end else begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
      if (valid_in) begin
        sr <= sr_n[30:0];
        case (state)
          SEARCH: begin
            // True polarity is tested first so it wins a tie.
            if (d <= S_TH || d_inv <= S_TH) begin
              state    <= DATA;
              inverted <= (d > S_TH);
              bit_cnt  <= '0;
              byte_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          DATA: begin
            byte_acc <= byte_nxt[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_out  <= byte_nxt;
              valid_out <= 1'b1;
              sof_out   <= (byte_cnt == '0);
              if (byte_cnt == LAST_BYTE) begin
                eof_out     <= 1'b1;
                frame_count <= frame_count + 16'd1;
                byte_cnt    <= '0;
                chk_cnt     <= '0;
                state       <= CHECK;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          CHECK: begin
            chk_cnt <= chk_cnt + 5'd1;
            if (chk_cnt == 5'd31) begin
              bit_cnt  <= '0;
              byte_cnt <= '0;
              if (d_sel <= L_TH) begin
                miss_cnt <= '0;
                state    <= DATA;
              end else begin
                miss_cnt <= miss_nxt;
                state    <= (miss_nxt == MISS_LIMIT) ? SEARCH : DATA;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cadu_frame_sync.sv
// Bench for cadu_frame_sync: a frame-position model of the sync rules is
// compared against the DUT every cycle, with literal spot checks on top.
module tb_cadu_frame_sync;

  localparam logic [31:0] ASM = 32'h1ACFFC1D;
  localparam int FB = 300;
  localparam int PB = FB * 8;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  byte_out;
  logic        valid_out, sof_out, eof_out, locked, inverted;
  logic [15:0] frame_count;

  cadu_frame_sync #(
    .ASM(ASM), .FRAME_BYTES(FB), .SEARCH_THRESH(0), .LOCK_THRESH(4), .MAX_MISSES(3)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bit_in(bit_in), .valid_in(valid_in),
    .byte_out(byte_out), .valid_out(valid_out), .sof_out(sof_out), .eof_out(eof_out),
    .locked(locked), .inverted(inverted), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nbytes = 0;
  int neof   = 0;
  logic [7:0] sof_byte = 8'hxx;
  logic [7:0] eof_byte = 8'hxx;
  bit gap_mode = 1'b0;

  // ---------------- model: position within the marker+payload period -------
  logic [31:0] m_hist = '0;
  bit          m_lock = 1'b0, m_inv = 1'b0, m_vin = 1'b0;
  int          m_pos = 0, m_miss = 0, m_dist;
  logic [7:0]  m_acc = '0;
  logic [15:0] m_fc = '0;
  bit          e_valid = 1'b0, e_sof = 1'b0, e_eof = 1'b0;
  logic [7:0]  e_byte = '0;

  initial forever begin
    @(posedge clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_hist = '0; m_lock = 0; m_inv = 0; m_vin = 0; m_pos = 0; m_miss = 0;
      m_acc = '0; m_fc = '0; e_valid = 0; e_sof = 0; e_eof = 0;
    end else begin
      e_valid = 0; e_sof = 0; e_eof = 0;
      m_vin = valid_in;
      if (valid_in) begin
        m_hist = {m_hist[30:0], bit_in};
        if (!m_lock) begin
          if ($countones(m_hist ^ ASM) == 0) begin
            m_lock = 1; m_inv = 0; m_pos = 0; m_miss = 0;
          end else if ($countones(m_hist ^ ~ASM) == 0) begin
            m_lock = 1; m_inv = 1; m_pos = 0; m_miss = 0;
          end
        end else if (m_pos < PB) begin
          m_acc = {m_acc[6:0], bit_in ^ m_inv};
          m_pos++;
          if (m_pos % 8 == 0) begin
            e_valid = 1; e_byte = m_acc;
            e_sof = (m_pos == 8);
            e_eof = (m_pos == PB);
            if (e_eof) m_fc++;
          end
        end else begin
          m_pos++;
          if (m_pos == PB + 32) begin
            m_dist = $countones(m_hist ^ (m_inv ? ~ASM : ASM));
            if (m_dist <= 4) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss == 3) m_lock = 0;
            end
            m_pos = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + byte monitor ------------------------
  initial forever begin
    @(negedge clk);
    checks++;
    if (valid_out !== e_valid || sof_out !== e_sof || eof_out !== e_eof ||
        locked !== m_lock || inverted !== m_inv || frame_count !== m_fc ||
        (e_valid && byte_out !== e_byte) || (valid_out === 1'b1 && !m_vin)) begin
      errors++;
      if (errors <= 20)
        $display("FAIL cycle_cmp t=%0t got v=%b s=%b e=%b b=%02h lk=%b inv=%b fc=%0d want v=%b s=%b e=%b b=%02h lk=%b inv=%b fc=%0d",
                 $time, valid_out, sof_out, eof_out, byte_out, locked, inverted, frame_count,
                 e_valid, e_sof, e_eof, e_byte, m_lock, m_inv, m_fc);
    end
    if (valid_out === 1'b1) begin
      nbytes++;
      if (sof_out) sof_byte = byte_out;
      if (eof_out) begin eof_byte = byte_out; neof++; end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    if (gap_mode)
      while ($urandom_range(0, 99) >= 40) begin
        @(negedge clk); valid_in = 1'b0; bit_in = 1'($urandom);
      end
    @(negedge clk); valid_in = 1'b1; bit_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); valid_in = 1'b0; end
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] err);
    logic [31:0] x;
    x = w ^ err;
    for (int i = 31; i >= 0; i--) send_bit(x[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic send_frame(input bit inv, input int nb);
    logic [7:0] v;
    for (int k = 0; k < nb; k++) begin
      v = 8'(k % 252);
      if (inv) v = ~v;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 sys_rst_n = 1'b0;
    repeat (4) begin @(negedge clk); bit_in = 1'($urandom); valid_in = 1'($urandom); end
    #1 nbytes = 0; neof = 0;
    @(negedge clk); sys_rst_n = 1'b1; valid_in = 1'b0;
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    repeat (6) begin @(negedge clk); bit_in = 1'($urandom); valid_in = 1'($urandom); end
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    @(negedge clk); sys_rst_n = 1'b1; valid_in = 1'b0;

    // clean acquisition, thresholds and flywheel loss in one locked run
    send_rand(16);
    send_word(ASM, 32'h0); idle(1);
    chk("acq_locked", 32'(locked), 32'd1);
    chk("acq_inverted", 32'(inverted), 32'd0);
    send_frame(0, FB); idle(1);
    chk("f1_fc", 32'(frame_count), 32'd1);
    chk("f1_sof_byte", 32'(sof_byte), 32'h00);
    chk("f1_eof_byte", 32'(eof_byte), 32'h2F);
    send_word(ASM, 32'h0); send_frame(0, FB); idle(2);
    chk("f2_fc", 32'(frame_count), 32'd2);
    chk("f2_nbytes", 32'(nbytes), 32'd600);
    send_word(ASM, 32'h80010201); send_frame(0, FB); idle(1);
    chk("err4_fc", 32'(frame_count), 32'd3);
    send_word(ASM, 32'h80010203); send_frame(0, FB); idle(1);
    chk("err5_fc", 32'(frame_count), 32'd4);
    chk("err5_locked", 32'(locked), 32'd1);
    send_word(ASM, 32'h0); send_frame(0, FB); idle(1);
    chk("f5_fc", 32'(frame_count), 32'd5);
    send_word(ASM, 32'hF00000F0); send_frame(0, FB); idle(1);
    chk("miss1_fc", 32'(frame_count), 32'd6);
    send_word(ASM, 32'h0F0000F0); send_frame(0, FB); idle(1);
    chk("miss2_fc", 32'(frame_count), 32'd7);
    chk("miss2_locked", 32'(locked), 32'd1);
    send_word(ASM, 32'h00F00F00); idle(1);
    chk("miss3_locked", 32'(locked), 32'd0);
    send_rand(40); idle(1);
    chk("lost_nbytes", 32'(nbytes), 32'd2100);
    send_word(ASM, 32'h0); send_frame(0, FB); idle(1);
    chk("reacq_fc", 32'(frame_count), 32'd8);
    chk("reacq_nbytes", 32'(nbytes), 32'd2400);

    // one bit error is not enough to acquire
    do_reset();
    send_rand(16); send_word(ASM, 32'h00010000); idle(1);
    chk("search_err1", 32'(locked), 32'd0);

    // inverted polarity
    do_reset();
    send_rand(16); send_word(~ASM, 32'h0); idle(1);
    chk("inv_flag", 32'(inverted), 32'd1);
    send_frame(1, FB); idle(1);
    chk("inv_fc", 32'(frame_count), 32'd1);
    chk("inv_sof_byte", 32'(sof_byte), 32'h00);
    chk("inv_eof_byte", 32'(eof_byte), 32'h2F);
    chk("inv_nbytes", 32'(nbytes), 32'd300);

    // gapped input
    do_reset();
    gap_mode = 1'b1;
    send_rand(16); send_word(ASM, 32'h0); send_frame(0, FB);
    send_word(ASM, 32'h0); send_frame(0, FB);
    gap_mode = 1'b0;
    idle(2);
    chk("gap_fc", 32'(frame_count), 32'd2);
    chk("gap_nbytes", 32'(nbytes), 32'd600);
    chk("gap_eof_byte", 32'(eof_byte), 32'h2F);

    // reset mid-frame
    do_reset();
    send_word(ASM, 32'h0); send_frame(0, 150); idle(1);
    chk("mid_nbytes", 32'(nbytes), 32'd150);
    @(negedge clk); #1 sys_rst_n = 1'b0; #1;
    chk("abort_locked", 32'(locked), 32'd0);
    chk("abort_valid", 32'(valid_out), 32'd0);
    chk("abort_fc", 32'(frame_count), 32'd0);
    idle(3);
    chk("abort_no_eof", 32'(neof), 32'd0);
    @(negedge clk); sys_rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
